// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: funct codes, alu_op encodings,
// and the multiply/divide state and op enums.
package ex_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;

  // Matches funct[1:0] of the mult/multu/div/divu group.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
interface ex_if;
  logic [2:0]  ex_ctrl;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [31:0] sign_extend;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] write_data;
  logic [4:0]  dest_reg;
  logic        stall;

  modport master (
    output ex_ctrl, reg1, reg2, sign_extend, funct, rt, rd,
    input  alu_result, zero, write_data, dest_reg, stall
  );

  modport slave (
    input  ex_ctrl, reg1, reg2, sign_extend, funct, rt, rd,
    output alu_result, zero, write_data, dest_reg, stall
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit owning HI/LO.
// The divider is only built when EX_DIV_EN is defined; otherwise div/divu are ignored.
module ex_muldiv
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state;
  logic [5:0]  count;
  logic        neg_a, neg_b;
  logic [31:0] mcand;   // |b|: multiplicand or divisor
  logic [63:0] acc;     // mul: {partial, multiplier}; div: {remainder, dividend}
  logic        sgn;
  logic        go;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt, mul_fix;

  assign sgn   = ~op[0];
  assign a_abs = (sgn & a[31]) ? -a : a;
  assign b_abs = (sgn & b[31]) ? -b : b;

  // Gating with rst_n keeps stall low while reset is held with an op still presented.
`ifdef EX_DIV_EN
  assign go = start & rst_n;
`else
  assign go = start & rst_n & ~op[1];
`endif

  assign busy = (state == IDLE) ? go : (state == MUL || state == DIV);

  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
  assign mul_nxt = {mul_sum, acc[31:1]};
  assign mul_fix = (neg_a ^ neg_b) ? -mul_nxt : mul_nxt;

`ifdef EX_DIV_EN
  logic [32:0] rem_sh, diff;
  logic [63:0] div_nxt;
  logic [31:0] quo, rem;
  assign rem_sh  = {acc[63:32], acc[31]};
  assign diff    = rem_sh - {1'b0, mcand};
  assign div_nxt = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                            : {diff[31:0],   acc[30:0], 1'b1};
  assign quo = div_nxt[31:0];
  assign rem = div_nxt[63:32];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      mcand <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          neg_a <= sgn & a[31];
          neg_b <= sgn & b[31];
          mcand <= b_abs;
          acc   <= {32'd0, a_abs};
          count <= '0;
`ifdef EX_DIV_EN
          state <= op[1] ? DIV : MUL;
`else
          state <= MUL;
`endif
        end
        MUL: begin
          acc   <= mul_nxt;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            {hi, lo} <= mul_fix;
            state    <= DONE;
          end
        end
`ifdef EX_DIV_EN
        DIV: begin
          acc   <= div_nxt;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            // Divide by zero leaves rem == |dividend|, so HI comes out as the dividend.
            lo    <= (mcand == '0) ? 32'hFFFF_FFFF : ((neg_a ^ neg_b) ? -quo : quo);
            hi    <= neg_a ? -rem : rem;
            state <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control, ALU, operand/destination muxes and the
// mult/div stall. Define EX_DIV_EN to build div/divu support.
module ex_stage
  import ex_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  ex_if.slave  bus
);

  logic        reg_dst;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic [31:0] opa, opb, res;
  logic [4:0]  shamt;
  logic        md_start, md_busy;
  logic [31:0] hi, lo;

  assign {reg_dst, alu_op} = bus.ex_ctrl;
  assign alu_src  = ~reg_dst & (alu_op != ALU_SUB);
  assign opa      = bus.reg1;
  assign opb      = alu_src ? bus.sign_extend : bus.reg2;
  assign shamt    = bus.sign_extend[10:6];
  assign md_start = (alu_op == ALU_RTYPE) && is_muldiv(bus.funct);

  ex_muldiv u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (md_op_e'(bus.funct[1:0])),
    .a     (bus.reg1),
    .b     (bus.reg2),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    res = '0;
    case (alu_op)
      ALU_SUB:   res = opa - opb;
      ALU_RTYPE: begin
        case (bus.funct)
          F_ADD, F_ADDU: res = opa + opb;
          F_SUB, F_SUBU: res = opa - opb;
          F_AND:  res = opa & opb;
          F_OR:   res = opa | opb;
          F_XOR:  res = opa ^ opb;
          F_NOR:  res = ~(opa | opb);
          F_SLT:  res = {31'd0, $signed(opa) < $signed(opb)};
          F_SLTU: res = {31'd0, opa < opb};
          F_SLL:  res = bus.reg2 << shamt;
          F_SRL:  res = bus.reg2 >> shamt;
          F_MFHI: res = hi;
          F_MFLO: res = lo;
          default: res = '0;   // mult/div group and unknown functs
        endcase
      end
      default: res = opa + opb;  // add, bubble
    endcase
  end

  assign bus.alu_result = res;
  assign bus.zero       = (res == '0);
  assign bus.write_data = bus.reg2;
  assign bus.dest_reg   = reg_dst ? bus.rd : bus.rt;
  assign bus.stall      = md_busy;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, fed by the ID/EX pipeline register and feeding the EX/MEM register. It holds three parts:
- a single-cycle ALU path with ALU control decode, operand select and destination-register select;
- an iterative multiply/divide unit that owns the HI/LO registers;
- a stall request that freezes PC, IF/ID and ID/EX while a multiply or divide is in progress.

## Interface
Parameters: none (width fixed at 32).
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_ctrl  in  3  {reg_dst, alu_op[1:0]} from ID/EX EX field; alu_op 00=add, 01=sub, 10=R-type (decode funct); alu_src = ~reg_dst & (alu_op != 01)
- reg1  in  32  rs operand
- reg2  in  32  rt operand
- sign_extend  in  32  sign-extended immediate; bits [10:6] double as shamt
- funct  in  6  R-type function field
- rt  in  5  rt register number
- rd  in  5  rd register number
- alu_result  out  32  ALU or mfhi/mflo result (combinational)
- zero  out  1  alu_result == 0
- write_data  out  32  reg2 passed through for stores
- dest_reg  out  5  reg_dst ? rd : rt
- stall  out  1  hold PC, IF/ID and ID/EX this cycle

## Operation
- R-type funct codes:
  - 100000/100001 add/addu: wrapping add.
  - 100010/100011 sub/subu: wrapping subtract.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt (signed), 101011 sltu: result 0/1.
  - 000000 sll, 000010 srl: shift reg2 by shamt.
  - 010000 mfhi, 010010 mflo: read HI or LO.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu: multiply/divide unit ops.
  - Any other funct: result 0.
- Signed add/sub overflow wraps; no exception is raised.
- Bubble (ex_ctrl=000) decodes as add; it has no side effects.
- For mult/div/divu/multu, alu_result is 0 and the EX/MEM write is the decoder's concern.
- Multiply/divide FSM states:
  - IDLE: a mult/div op with alu_op=10 asserts stall combinationally in the same cycle. On the edge it latches |reg1|, |reg2| and the sign flags, clears count, and moves to MUL or DIV.
  - MUL: radix-2 shift-add, one bit per cycle, stall=1. After 32 iterations it writes the sign-corrected {HI,LO} and moves to DONE.
  - DIV: restoring shift-subtract, one quotient bit per cycle, stall=1. After 32 iterations it writes LO=quotient, HI=remainder, sign-corrected (remainder takes the dividend's sign), and moves to DONE.
  - DONE: stall=0 so the held instruction retires. The instruction is not restarted, even though the same mult/div is still presented. Always returns to IDLE next cycle.
- Divide by zero: LO=32'hFFFF_FFFF, HI=dividend. Still takes the full 32 cycles; no trap.
- mfhi/mflo read HI/LO combinationally. They cannot observe a busy unit, because the pipeline is frozen while the unit is busy.

## Timing
- ALU path: 0-cycle combinational; it is captured by the EX/MEM register on the next edge.
- mult/div: stall is high in cycle 0 (issue) and cycles 1–32, 33 cycles in total. HI/LO are valid from cycle 33 (DONE).
- An mfhi in the instruction immediately following sees the new value with no extra stall.
- Back-to-back mult ops: the second is issued from IDLE on cycle 34.
- Reset, asserted at any time including mid-operation: FSM=IDLE, count=0, HI=LO=0, stall=0. The combinational outputs follow their inputs.

## Configuration
- EX_DIV_EN defined: div/divu are fully supported as above.
- EX_DIV_EN undefined: the DIV state and divider datapath are not built. div/divu decode as no-ops: no stall, HI/LO unchanged, alu_result 0.
- mult/multu are unaffected by EX_DIV_EN.

## Structure
- Package ex_pkg holds:
  - funct localparams;
  - alu_op encodings (ALU_ADD, ALU_SUB, ALU_RTYPE);
  - muldiv state enum {IDLE, MUL, DIV, DONE}.
- Sub-module ex_muldiv contains the FSM, the 6-bit counter, the operand/accumulator registers and HI/LO. Its interface is start, op, a, b, busy, hi, lo.
- The top level ex_stage contains ALU control, the ALU, the operand and destination muxes, and the stall combine.

## Test plan
- add: reg1=7, reg2=-3, ex_ctrl=110, funct=100000 -> alu_result=4, dest_reg=rd, stall=0. sw with imm 8 (ex_ctrl=000, reg1=0x100) -> 0x108, dest_reg=rt.
- slt/sltu: reg1=0xFFFF_FFFF, reg2=1 -> slt=1, sltu=0. beq (ex_ctrl=001) with equal operands -> zero=1.
- mult: reg1=-6, reg2=7 -> stall high for exactly 33 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFD6. A following mflo returns 0xFFFF_FFD6 with no stall.
- div: reg1=-17, reg2=5 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFE (-2). divu by 0 with reg1=9 -> LO=0xFFFF_FFFF, HI=9.
- Assert rst_n low at cycle 10 of a mult -> stall=0 immediately, HI=LO=0. After release, an mflo returns 0 and a new mult issues normally.
- Build without EX_DIV_EN: div issued -> stall never rises, HI/LO keep their prior mult results.
